// File: rtl/apb_intercon_rr.sv
// Multi-master APB interconnect: round-robin arbitration across the masters,
// a registered IDLE/SETUP/ACCESS transfer FSM toward the slaves, and an
// address decoder. Unmapped addresses and hung slaves complete with PSLVERR.
module apb_intercon_rr #(
  parameter int BUS_WIDTH      = 16,
  parameter int MASTER_PORTS   = 4,
  parameter int SLAVE_PORTS    = 6,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE =
    {16'h8000, 16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_LIMIT =
    {16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h2FFF, 16'h1FFF, 16'h0FFF},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY,
  input  logic [SLAVE_PORTS-1:0]            M_PSLVERR
);

  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int IW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GW-1:0] GRANT_RST = GW'(MASTER_PORTS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, last_grant_q;
  logic [BUS_WIDTH-1:0]  paddr_q, pwdata_q;
  logic                  pwrite_q;
  logic                  hit_q;
  logic [IW-1:0]         idx_q;
  logic [CW-1:0]         cnt_q;

  logic [BUS_WIDTH-1:0]  s_addr  [MASTER_PORTS];
  logic [BUS_WIDTH-1:0]  s_wdata [MASTER_PORTS];
  logic [BUS_WIDTH-1:0]  m_rdata [SLAVE_PORTS];
  logic [BUS_WIDTH-1:0]  base_a  [SLAVE_PORTS];
  logic [BUS_WIDTH-1:0]  limit_a [SLAVE_PORTS];

  logic                  arb_found;
  logic [GW-1:0]         arb_grant;
  logic                  dec_hit;
  logic [IW-1:0]         dec_idx;
  logic                  req_live, slv_ready, timeout_hit, complete;
  logic                  resp_err;
  logic [BUS_WIDTH-1:0]  resp_data;
  logic                  unused_penable;

  // PENABLE from the masters carries no information: the FSM generates the phases
  assign unused_penable = ^S_PENABLE;

  for (genvar g = 0; g < MASTER_PORTS; g++) begin : g_mst
    assign s_addr[g]  = S_PADDR[g*BUS_WIDTH +: BUS_WIDTH];
    assign s_wdata[g] = S_PWDATA[g*BUS_WIDTH +: BUS_WIDTH];
    assign S_PREADY[g]  = complete && (grant_q == GW'(g));
    assign S_PSLVERR[g] = complete && (grant_q == GW'(g)) && resp_err;
    assign S_PRDATA[g*BUS_WIDTH +: BUS_WIDTH] =
      (complete && (grant_q == GW'(g))) ? resp_data : '0;
  end

  for (genvar g = 0; g < SLAVE_PORTS; g++) begin : g_slv
    assign m_rdata[g] = M_PRDATA[g*BUS_WIDTH +: BUS_WIDTH];
    assign base_a[g]  = SLAVE_BASE[g*BUS_WIDTH +: BUS_WIDTH];
    assign limit_a[g] = SLAVE_LIMIT[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Round-robin pick: first requester at or after last_grant+1, wrapping
  always_comb begin
    int            c;
    logic [GW-1:0] cand;
    arb_found = 1'b0;
    arb_grant = '0;
    c         = 0;
    cand      = '0;
    for (int k = 0; k < MASTER_PORTS; k++) begin
      c = int'(last_grant_q) + 1 + k;
      if (c >= MASTER_PORTS) c = c - MASTER_PORTS;
      if (c >= MASTER_PORTS) c = c - MASTER_PORTS;
      cand = GW'(c);
      if (!arb_found && S_PSELx[cand]) begin
        arb_found = 1'b1;
        arb_grant = cand;
      end
    end
  end

  // Address decode of the winning master; lowest-index range wins on overlap
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < SLAVE_PORTS; i++) begin
      if (!dec_hit && (s_addr[arb_grant] >= base_a[i]) && (s_addr[arb_grant] <= limit_a[i])) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  // Completion condition and the response routed back to the granted master
  always_comb begin
    req_live    = S_PSELx[grant_q];
    slv_ready   = hit_q && M_PREADY[idx_q];
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    complete    = (state_q == ACCESS) && req_live && (!hit_q || slv_ready || timeout_hit);
    resp_err    = slv_ready ? M_PSLVERR[idx_q] : 1'b1;
    resp_data   = slv_ready ? m_rdata[idx_q] : '0;
  end

  // Next-state logic of the transfer FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_found) state_d = SETUP;
      SETUP:   state_d = req_live ? ACCESS : IDLE;
      ACCESS:  if (!req_live || complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side strobes follow the FSM phase and the latched decode
  always_comb begin
    M_PSELx = '0;
    if ((state_q != IDLE) && hit_q) M_PSELx[idx_q] = 1'b1;
    M_PENABLE = (state_q == ACCESS);
  end

  assign M_PADDR  = paddr_q;
  assign M_PWRITE = pwrite_q;
  assign M_PWDATA = pwdata_q;

  // FSM state, grant bookkeeping, latched transfer and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_RST;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (arb_found) begin
          grant_q  <= arb_grant;
          paddr_q  <= s_addr[arb_grant];
          pwrite_q <= S_PWRITE[arb_grant];
          pwdata_q <= s_wdata[arb_grant];
          hit_q    <= dec_hit;
          idx_q    <= dec_idx;
        end
      end else if (state_d == IDLE) begin
        // Completion and abort both advance the pointer so nobody starves
        last_grant_q <= grant_q;
        cnt_q        <= '0;
      end else if (state_q == ACCESS && cnt_q != {CW{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Bench for apb_intercon_rr: a 4-master/6-slave instance with an 8-cycle
// timeout, plus a 1-master 32-bit instance with overlapping slave ranges.
// Expected completions are queued by the stimulus and popped by monitors.
module tb_apb_intercon_rr;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-master instance ----------------
  logic [63:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [3:0]  S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, S_PSLVERR;
  logic [15:0] M_PADDR, M_PWDATA;
  logic        M_PWRITE, M_PENABLE;
  logic [5:0]  M_PSELx, M_PREADY, M_PSLVERR;
  logic [95:0] M_PRDATA;

  int          wait_n = 0;
  logic        hang = 1'b0;
  logic [5:0]  err_mask = 6'b0;
  int          acc_cnt;
  logic        slv_rdy;

  assign S_PENABLE = S_PSELx;
  assign M_PRDATA  = {16'hA005, 16'hBEEF, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
  assign slv_rdy   = M_PENABLE && !hang && (acc_cnt >= wait_n);
  assign M_PREADY  = slv_rdy ? M_PSELx : 6'b0;
  assign M_PSLVERR = err_mask;

  // slave wait-state model: counts ACCESS cycles of the current transfer
  always @(posedge clk or negedge reset)
    if (!reset) acc_cnt <= 0;
    else if (M_PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  apb_intercon_rr #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
  );

  // ---------------- 1-master 32-bit instance ----------------
  logic [31:0] S1_PADDR, S1_PWDATA, S1_PRDATA, M1_PADDR, M1_PWDATA;
  logic [0:0]  S1_PWRITE, S1_PSELx, S1_PENABLE, S1_PREADY, S1_PSLVERR;
  logic        M1_PWRITE, M1_PENABLE;
  logic [1:0]  M1_PSELx, M1_PREADY, M1_PSLVERR;
  logic [63:0] M1_PRDATA;

  assign S1_PENABLE = S1_PSELx;
  assign M1_PRDATA  = {32'h2222_2222, 32'hCAFE_F00D};
  assign M1_PREADY  = M1_PENABLE ? M1_PSELx : 2'b0;
  assign M1_PSLVERR = 2'b0;

  apb_intercon_rr #(
    .BUS_WIDTH(32), .MASTER_PORTS(1), .SLAVE_PORTS(2),
    .SLAVE_BASE ({32'h0000_0000, 32'h1000_0000}),
    .SLAVE_LIMIT({32'hFFFF_FFFF, 32'h1FFF_FFFF})
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .S_PADDR(S1_PADDR), .S_PWRITE(S1_PWRITE), .S_PSELx(S1_PSELx), .S_PENABLE(S1_PENABLE),
    .S_PWDATA(S1_PWDATA), .S_PRDATA(S1_PRDATA), .S_PREADY(S1_PREADY), .S_PSLVERR(S1_PSLVERR),
    .M_PADDR(M1_PADDR), .M_PWRITE(M1_PWRITE), .M_PSELx(M1_PSELx), .M_PENABLE(M1_PENABLE),
    .M_PWDATA(M1_PWDATA), .M_PRDATA(M1_PRDATA), .M_PREADY(M1_PREADY), .M_PSLVERR(M1_PSLVERR)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          m;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect0(input int m, input logic err, input logic [31:0] d, input int c);
    q0.push_back('{m: m, err: err, data: d, cyc: c});
  endtask

  task automatic expect1(input logic [31:0] d, input int c);
    q1.push_back('{m: 0, err: 1'b0, data: d, cyc: c});
  endtask

  exp_t        me0, me1;
  logic [3:0]  e_lane0, e_err0;
  logic [63:0] e_dat0;

  // monitor for the 4-master instance
  always @(negedge clk) begin
    if (S_PREADY != 4'b0) begin
      if (q0.size() == 0) begin
        chk("unexpected_ready0", {60'b0, S_PREADY}, 64'b0);
      end else begin
        me0 = q0.pop_front();
        e_lane0 = 4'b0;
        e_err0  = 4'b0;
        e_dat0  = 64'b0;
        e_lane0[me0.m] = 1'b1;
        e_err0[me0.m]  = me0.err;
        e_dat0[me0.m*16 +: 16] = me0.data[15:0];
        chk("ready_lane", {60'b0, S_PREADY}, {60'b0, e_lane0});
        chk("pslverr", {60'b0, S_PSLVERR}, {60'b0, e_err0});
        chk("prdata", S_PRDATA, e_dat0);
        chk("ready_cycle", 64'(cyc), 64'(me0.cyc));
      end
    end
  end

  // monitor for the 32-bit instance
  always @(negedge clk) begin
    if (S1_PREADY != 1'b0) begin
      if (q1.size() == 0) begin
        chk("unexpected_ready1", {63'b0, S1_PREADY}, 64'b0);
      end else begin
        me1 = q1.pop_front();
        chk("w32_pslverr", {63'b0, S1_PSLVERR}, {63'b0, me1.err});
        chk("w32_prdata", {32'b0, S1_PRDATA}, {32'b0, me1.data});
        chk("w32_ready_cycle", 64'(cyc), 64'(me1.cyc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input int m, input logic [15:0] a, input logic w, input logic [15:0] d);
    S_PADDR[m*16 +: 16]  = a;
    S_PWRITE[m]          = w;
    S_PWDATA[m*16 +: 16] = d;
  endtask

  // hold requests until each master is answered, then drop its select
  task automatic drain0(input int maxc);
    int n;
    logic [3:0] r;
    n = 0;
    while (S_PSELx != 4'b0 && n < maxc) begin
      @(negedge clk);
      n++;
      r = S_PREADY;
      if (r != 4'b0) begin
        #1;
        S_PSELx = S_PSELx & ~r;
      end
    end
    if (S_PSELx != 4'b0) begin
      chk("drain0_bound", {60'b0, S_PSELx}, 64'b0);
      S_PSELx = 4'b0;
    end
  endtask

  task automatic drain1(input int maxc);
    int n;
    n = 0;
    while (S1_PSELx != 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
      if (S1_PREADY != 1'b0) begin
        #1;
        S1_PSELx = 1'b0;
      end
    end
    if (S1_PSELx != 1'b0) begin
      chk("drain1_bound", {63'b0, S1_PSELx}, 64'b0);
      S1_PSELx = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_psel"},    {58'b0, M_PSELx}, 64'b0);
    chk({tag, "_m_penable"}, {63'b0, M_PENABLE}, 64'b0);
    chk({tag, "_m_paddr"},   {48'b0, M_PADDR}, 64'b0);
    chk({tag, "_m_pwrite"},  {63'b0, M_PWRITE}, 64'b0);
    chk({tag, "_m_pwdata"},  {48'b0, M_PWDATA}, 64'b0);
    chk({tag, "_s_pready"},  {60'b0, S_PREADY}, 64'b0);
    chk({tag, "_s_pslverr"}, {60'b0, S_PSLVERR}, 64'b0);
    chk({tag, "_s_prdata"},  S_PRDATA, 64'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c;

  initial begin
    reset     = 1'b0;
    S_PADDR   = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0;
    S1_PADDR  = '0; S1_PWDATA = '0; S1_PWRITE = '0; S1_PSELx = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // M0 + M2 together: M0 first, then M2 after one IDLE cycle
    c = cyc;
    set_m(0, 16'h1004, 1'b0, 16'h0);
    set_m(2, 16'h2000, 1'b0, 16'h0);
    S_PSELx = 4'b0101;
    expect0(0, 1'b0, 32'hA001, c + 2);
    expect0(2, 1'b0, 32'hA002, c + 5);
    drain0(40);

    // M1 + M2 with pointer at M2: M1 first, then M2
    @(negedge clk);
    c = cyc;
    set_m(1, 16'h3010, 1'b1, 16'h5A5A);
    set_m(2, 16'h0008, 1'b0, 16'h0);
    S_PSELx = 4'b0110;
    expect0(1, 1'b0, 32'hA003, c + 2);
    expect0(2, 1'b0, 32'hA000, c + 5);
    @(negedge clk);
    chk("setup_psel_wr", {58'b0, M_PSELx}, 64'h08);
    chk("setup_pwdata", {48'b0, M_PWDATA}, 64'h5A5A);
    chk("setup_pwrite", {63'b0, M_PWRITE}, 64'h1);
    drain0(40);

    // M0 read of BRAM0 with 3 wait states
    @(negedge clk);
    c = cyc;
    wait_n = 3;
    set_m(0, 16'h4ABC, 1'b0, 16'h0);
    S_PSELx = 4'b0001;
    expect0(0, 1'b0, 32'hBEEF, c + 5);
    @(negedge clk);
    chk("bram_setup_psel", {58'b0, M_PSELx}, 64'h10);
    chk("bram_setup_penable", {63'b0, M_PENABLE}, 64'h0);
    chk("bram_setup_paddr", {48'b0, M_PADDR}, 64'h4ABC);
    @(negedge clk);
    chk("bram_access_penable", {63'b0, M_PENABLE}, 64'h1);
    chk("bram_access_psel", {58'b0, M_PSELx}, 64'h10);
    drain0(40);
    wait_n = 0;

    // M1 write to an unmapped address: error completion in the first ACCESS cycle
    @(negedge clk);
    c = cyc;
    set_m(1, 16'hC000, 1'b1, 16'h1234);
    S_PSELx = 4'b0010;
    expect0(1, 1'b1, 32'h0, c + 2);
    @(negedge clk);
    chk("unmapped_psel", {58'b0, M_PSELx}, 64'h0);
    drain0(40);

    // slave-signalled error is passed through together with its data
    @(negedge clk);
    c = cyc;
    err_mask = 6'b100000;
    set_m(3, 16'h9000, 1'b0, 16'h0);
    S_PSELx = 4'b1000;
    expect0(3, 1'b1, 32'hA005, c + 2);
    drain0(40);
    err_mask = 6'b0;

    // hung slave: timeout after 8 ACCESS cycles, then back to IDLE
    @(negedge clk);
    c = cyc;
    hang = 1'b1;
    set_m(2, 16'h2000, 1'b0, 16'h0);
    S_PSELx = 4'b0100;
    expect0(2, 1'b1, 32'h0, c + 9);
    drain0(30);
    hang = 1'b0;
    @(negedge clk);
    chk("timeout_idle_penable", {63'b0, M_PENABLE}, 64'h0);
    chk("timeout_idle_psel", {58'b0, M_PSELx}, 64'h0);

    // M0 drops its request mid-ACCESS: abort without completion, pointer moves past M0
    @(negedge clk);
    wait_n = 3;
    set_m(0, 16'h4000, 1'b0, 16'h0);
    S_PSELx = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("drop_in_access", {63'b0, M_PENABLE}, 64'h1);
    S_PSELx = 4'b0000;
    @(negedge clk);
    chk("drop_penable", {63'b0, M_PENABLE}, 64'h0);
    chk("drop_psel", {58'b0, M_PSELx}, 64'h0);
    wait_n = 0;
    @(negedge clk);
    c = cyc;
    set_m(1, 16'h1000, 1'b0, 16'h0);
    S_PSELx = 4'b0011;
    expect0(1, 1'b0, 32'hA001, c + 2);
    expect0(0, 1'b0, 32'hBEEF, c + 5);
    drain0(40);

    // reset during ACCESS (pointer currently at M0) clears everything at once
    @(negedge clk);
    hang = 1'b1;
    set_m(0, 16'h2000, 1'b0, 16'h0);
    S_PSELx = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_access", {63'b0, M_PENABLE}, 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    S_PSELx = 4'b0;
    hang = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // pointer restarts at M0: M0+M3 gives M0 then M3; then M3 alone
    @(negedge clk);
    c = cyc;
    set_m(0, 16'h1000, 1'b0, 16'h0);
    set_m(3, 16'h2000, 1'b0, 16'h0);
    S_PSELx = 4'b1001;
    expect0(0, 1'b0, 32'hA001, c + 2);
    expect0(3, 1'b0, 32'hA002, c + 5);
    drain0(40);
    @(negedge clk);
    c = cyc;
    set_m(3, 16'h3000, 1'b0, 16'h0);
    S_PSELx = 4'b1000;
    expect0(3, 1'b0, 32'hA003, c + 2);
    drain0(40);

    // single master, 32-bit, overlapping ranges: lowest index wins
    @(negedge clk);
    c = cyc;
    S1_PADDR  = 32'h1234_5678;
    S1_PWRITE = 1'b0;
    S1_PSELx  = 1'b1;
    expect1(32'hCAFE_F00D, c + 2);
    @(negedge clk);
    chk("w32_overlap_psel", {62'b0, M1_PSELx}, 64'h1);
    chk("w32_paddr", {32'b0, M1_PADDR}, 64'h1234_5678);
    drain1(40);
    @(negedge clk);
    c = cyc;
    S1_PADDR  = 32'h2000_0000;
    S1_PWRITE = 1'b1;
    S1_PWDATA = 32'hDEAD_BEEF;
    S1_PSELx  = 1'b1;
    expect1(32'h2222_2222, c + 2);
    @(negedge clk);
    chk("w32_upper_psel", {62'b0, M1_PSELx}, 64'h2);
    chk("w32_pwdata", {32'b0, M1_PWDATA}, 64'hDEAD_BEEF);
    chk("w32_pwrite", {63'b0, M1_PWRITE}, 64'h1);
    drain1(40);

    repeat (3) @(negedge clk);
    chk("q0_outstanding", 64'(q0.size()), 64'h0);
    chk("q1_outstanding", 64'(q1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
